// File: rtl/game_port_ctrl.sv
// Apple IIgs game-port block: paddle RC-timeout emulation from MiSTer axes plus pushbutton reads.
// Reads are combinational off registered state; timers load on a $C070 access and count down on cpu_ce.
module game_port_ctrl #(
  parameter int CNT_W       = 12,
  parameter int AXIS_OFFSET = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic       io_sel,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] joy_x0,
  input  logic [7:0] joy_y0,
  input  logic [7:0] joy_x1,
  input  logic [7:0] joy_y1,
  input  logic [2:0] buttons,
  output logic [7:0] dout,
  output logic       dout_hit
);

  localparam logic [7:0] OFFSET = AXIS_OFFSET[7:0];

  logic [7:0]       joy     [4];
  logic [7:0]       pdl     [4];
  logic [CNT_W-1:0] timeout [4];
  logic [CNT_W-1:0] cnt     [4];
  logic [3:0]       timing;
  logic [2:0]       pb_meta;
  logic [2:0]       pb_sync;
  logic             trig;

  assign joy[0] = joy_x0;
  assign joy[1] = joy_y0;
  assign joy[2] = joy_x1;
  assign joy[3] = joy_y1;

  assign trig = io_sel && (addr == 8'h70);

  // Timeout approximates the IIgs paddle RC constant: pdl*11.25 CPU cycles.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pdl[i]     = joy[i] + OFFSET;
      timeout[i] = CNT_W'(pdl[i]) * CNT_W'(11) + CNT_W'(pdl[i] >> 2);
      timing[i]  = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (trig) begin
      for (int i = 0; i < 4; i++) cnt[i] <= timeout[i];
    end else if (cpu_ce) begin
      for (int i = 0; i < 4; i++)
        if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pb_meta <= '0;
      pb_sync <= '0;
    end else begin
      pb_meta <= buttons;
      pb_sync <= pb_meta;
    end
  end

  // $C070 reads trigger the timers but are deliberately not claimed on the data mux.
  always_comb begin
    dout     = '0;
    dout_hit = 1'b0;
    if (!reset && io_sel && rw) begin
      case (addr)
        8'h61: begin dout_hit = 1'b1; dout[7] = pb_sync[0]; end
        8'h62: begin dout_hit = 1'b1; dout[7] = pb_sync[1]; end
        8'h63: begin dout_hit = 1'b1; dout[7] = pb_sync[2]; end
        8'h64, 8'h65, 8'h66, 8'h67: begin
          dout_hit = 1'b1;
          dout[7]  = timing[addr[1:0]];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_port_ctrl.sv
// Scoreboard bench for game_port_ctrl: a pulse-counting reference model predicts every CPU access,
// a negedge monitor pops and compares.
module tb_game_port_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_ce = 1'b0;
  logic       io_sel = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] joy_x0 = 8'h80, joy_y0 = 8'h80, joy_x1 = 8'h80, joy_y1 = 8'h80;
  logic [2:0] buttons = 3'b000;
  logic [7:0] dout;
  logic       dout_hit;

  game_port_ctrl dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .io_sel(io_sel), .rw(rw), .addr(addr),
    .joy_x0(joy_x0), .joy_y0(joy_y0), .joy_x1(joy_x1), .joy_y1(joy_y1),
    .buttons(buttons), .dout(dout), .dout_hit(dout_hit)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel timeout latched at trigger, one shared count of
  // cpu_ce pulses since that trigger; a channel is timing while pulses < timeout.
  int         tout [4];
  int         pulses;
  logic [2:0] b_d1, b_d2;

  logic [16:0] exp_q [$];   // {addr, hit, dout}
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int tmo(input logic [7:0] j);
    logic [7:0] p;
    p = j + 8'd128;
    return int'(p) * 11 + int'(p) / 4;
  endfunction

  function automatic logic [8:0] predict(input logic r, input logic [7:0] a, input logic rst);
    logic [7:0] j [4];
    j = '{8'h0, 8'h0, 8'h0, 8'h0};
    if (rst || !r) return 9'h000;
    if (a >= 8'h61 && a <= 8'h63) return {1'b1, b_d2[a - 8'h61], 7'b0};
    if (a >= 8'h64 && a <= 8'h67) return {1'b1, (pulses < tout[a - 8'h64]), 7'b0};
    return 9'h000;
  endfunction

  task automatic cyc(input bit ce, input bit sel, input bit r, input logic [7:0] a,
                     input bit rst = 1'b0);
    cpu_ce = ce; io_sel = sel; rw = r; addr = a; reset = rst;
    if (sel) exp_q.push_back({a, predict(r, a, rst)});
    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 4; n++) tout[n] = 0;
      pulses = 0; b_d1 = 3'b0; b_d2 = 3'b0;
    end else begin
      b_d2 = b_d1; b_d1 = buttons;
      if (sel && a == 8'h70) begin
        tout[0] = tmo(joy_x0); tout[1] = tmo(joy_y0);
        tout[2] = tmo(joy_x1); tout[3] = tmo(joy_y1);
        pulses = 0;
      end else if (ce) begin
        pulses++;
      end
    end
    #1;
    cpu_ce = 1'b0; io_sel = 1'b0; rw = 1'b0; reset = 1'b0;
  endtask

  function automatic logic [7:0] rd_addr();
    logic [7:0] tbl [10];
    tbl = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h00, 8'h60};
    return tbl[$urandom_range(0, 9)];
  endfunction

  // Count n pulses, cpu_ce every `per` clks; reads interleaved, watched address every pulse.
  task automatic run_pulses(input int n, input int per, input logic [7:0] watch);
    for (int p = 0; p < n; p++)
      for (int k = 0; k < per; k++) begin
        if (k == 0)             cyc(1'b0, 1'b1, 1'b1, watch);
        else if (k == per - 1)  cyc(1'b1, 1'b0, 1'b0, 8'h00);
        else                    cyc(1'b0, $urandom_range(0, 1), 1'b1, rd_addr());
      end
  endtask

  always @(negedge clk) begin
    if (io_sel) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL no_expect addr=%h got hit=%b dout=%h want nothing", addr, dout_hit, dout);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({dout_hit, dout} !== e[8:0]) begin
          n_bad++;
          $display("FAIL read_%h t=%0t got hit=%b dout=%h want hit=%b dout=%h",
                   e[16:9], $time, dout_hit, dout, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 4; n++) tout[n] = 0;
    pulses = 0; b_d1 = 3'b0; b_d2 = 3'b0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 1'b1, 8'h64, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset state: all paddles idle
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'h64 + 8'(i));

    // PDL0 centred (timeout 1440), others at minimum
    joy_x0 = 8'h00; joy_y0 = 8'h80; joy_x1 = 8'h80; joy_y1 = 8'h80;
    cyc(1'b0, 1'b1, 1'b0, 8'h70);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'h64 + 8'(i));
    run_pulses(1445, 4, 8'h64);

    // PDL3 full scale (2868), axis moves mid-count
    joy_y1 = 8'h7f;
    cyc(1'b0, 1'b1, 1'b0, 8'h70);
    run_pulses(1000, 2, 8'h67);
    joy_y1 = 8'h80;
    run_pulses(1872, 2, 8'h67);

    // Trigger coincident with cpu_ce, re-trigger at pulse 500
    joy_x0 = 8'h00; joy_y1 = 8'h10;
    cyc(1'b1, 1'b1, 1'b0, 8'h70);
    run_pulses(500, 2, 8'h64);
    cyc(1'b1, 1'b1, 1'b1, 8'h70);
    run_pulses(1443, 2, 8'h64);

    // Reset mid-count with a coincident trigger
    joy_y0 = 8'h00;
    cyc(1'b0, 1'b1, 1'b0, 8'h70);
    run_pulses(100, 2, 8'h65);
    cyc(1'b0, 1'b1, 1'b0, 8'h70, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h65);
    run_pulses(5, 2, 8'h65);

    // Button synchroniser latency and an unmapped read
    buttons = 3'b010;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'h62);
    cyc(1'b0, 1'b1, 1'b1, 8'h68);
    cyc(1'b0, 1'b1, 1'b0, 8'h62);

    // Randomised traffic
    for (int i = 0; i < 8000; i++) begin
      logic [7:0] a;
      if ($urandom_range(0, 49) == 0) begin
        joy_x0 = $urandom_range(0, 1) ? 8'($urandom) : 8'h80 + 8'($urandom_range(0, 7));
        joy_y0 = $urandom_range(0, 1) ? 8'($urandom) : 8'h80 + 8'($urandom_range(0, 7));
        joy_x1 = $urandom_range(0, 1) ? 8'($urandom) : 8'h80 + 8'($urandom_range(0, 7));
        joy_y1 = $urandom_range(0, 1) ? 8'($urandom) : 8'h80 + 8'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 19) == 0) buttons = 3'($urandom);
      a = ($urandom_range(0, 59) == 0) ? 8'h70 : rd_addr();
      cyc($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, a,
          $urandom_range(0, 1999) == 0);
    end

    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
